// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: sequential PC issue, in-order response queue, redirect flush.
// Latency: request accepted at t, response at t+L, instruction visible to decode at t+L+1.
// Backpressure: requests are credit-limited by inflight+queued <= QUEUE_DEPTH; decode stalls via instr_ready.

// Small flushable circular FIFO holding {instruction, pc} entries.
// Latency: one cycle from push to head visibility (no bypass).
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fetch_queue_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer and occupancy update; a flush voids any same-cycle push or pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        wr_d = wr_q + PW'(1);
      end
      if (pop_i) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (rst && push_i && !flush_i) begin
      mem_q[wr_q] <= push_dat_i;
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rd_q];
  assign count_o    = cnt_q;

endmodule

module fetch_queue_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction memory request channel
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  // instruction memory response channel (in order, never stalled)
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  // decode channel
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  // control-flow redirect
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_W = (CW+1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic [CW-1:0]         q_count;
  entry_t                q_head;
  entry_t                q_push_dat;
  logic [CW:0]           outstanding;
  logic [ADDR_WIDTH-1:0] redirect_pc_al;
  logic                  req_fire;
  logic                  q_push;
  logic                  q_pop;

  assign redirect_pc_al = redirect_pc & PC_MASK;

  // Every request ever issued either sits in memory or in the queue, so this sum is the
  // credit check that keeps the queue from overflowing.
  assign outstanding = {1'b0, inflight_q} + {1'b0, q_count};

  assign imem_req_valid = (state_q != ST_IDLE) && !redirect && (outstanding < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to pre-redirect requests are discarded while drop_q is non-zero.
  assign q_push     = imem_resp_valid && (drop_q == '0) && !redirect;
  assign q_pop      = instr_valid && instr_ready && !redirect;
  assign q_push_dat = '{dat: imem_resp_data, pc: resp_pc_q};

  fetch_queue_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (q_push),
    .push_dat_i (q_push_dat),
    .pop_i      (q_pop),
    .head_dat_o (q_head),
    .count_o    (q_count)
  );

  // When empty, instr_out reads zero and pc_out shows the PC the next response will carry.
  assign instr_valid = (q_count != '0);
  assign instr_out   = instr_valid ? q_head.dat : '0;
  assign pc_out      = instr_valid ? q_head.pc  : resp_pc_q;

  // Next-state for PCs, credit counters and the fetch FSM; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);

    if (redirect) begin
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      // A response arriving this very cycle is already counted as dropped.
      drop_d     = inflight_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (q_push) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect && (drop_d != '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A redirect here simply reloads drop_d; stay until nothing stale remains.
        if (drop_d == '0) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit with an in-order memory model and a
// transaction-level reference: requests tagged with a redirect epoch, stale ones discarded.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_queue_unit #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          ep;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } ent_t;

  mreq_t       memq[$];   // accepted requests awaiting a memory response
  ent_t        mq[$];     // instructions decode should see, oldest first
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          resp_pct = 100;
  int          epoch = 0;
  int          n_acc = 0;
  int          n_fire = 0;
  int          first_iv = -1;
  bit          prev_rst_low = 1'b0;
  bit          saw_wrap = 1'b0;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] last_acc_addr = 32'h1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are checked against the
  // reference, then the reference absorbs this cycle's handshakes.
  task automatic step();
    mreq_t e;
    ent_t  n;
    mreq_t m;
    bit    give;
    bit    acc;
    bit    fire;
    int    outst;
    @(negedge clk);
    outst = memq.size() + mq.size();
    give  = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
      e    = memq.pop_front();
      give = 1'b1;
    end
    imem_resp_valid = give;
    imem_resp_data  = give ? word_of(e.addr) : $urandom;
    #1;
    if (cyc > 0) begin
      if (prev_rst_low) begin
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_pc_out", pc_out, RESET_PC);
      end
      chk("req_valid", imem_req_valid,
          32'(!prev_rst_low && !redirect && (outst < DEPTH)));
      chk("instr_valid", instr_valid, 32'(mq.size() != 0));
      if (instr_valid && mq.size() != 0) begin
        chk("instr_out", instr_out, mq[0].dat);
        chk("pc_out", pc_out, mq[0].pc);
      end
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    end
    if (instr_valid && first_iv < 0) first_iv = cyc;
    if (!rst) begin
      memq.delete();
      mq.delete();
      exp_req      = RESET_PC;
      prev_rst_low = 1'b1;
    end else begin
      acc  = imem_req_valid && imem_req_ready;
      fire = instr_valid && instr_ready && !redirect;
      if (redirect) begin
        epoch++;
        mq.delete();
        exp_req = redirect_pc & ~32'h3;
      end
      if (acc) begin
        m.due  = cyc + lat;
        m.addr = imem_req_addr;
        m.ep   = epoch;
        memq.push_back(m);
        if (last_acc_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0) saw_wrap = 1'b1;
        last_acc_addr = imem_req_addr;
        exp_req = exp_req + 32'd4;
        n_acc++;
      end
      if (fire && mq.size() != 0) begin
        void'(mq.pop_front());
        n_fire++;
      end
      if (give && e.ep == epoch) begin
        n.pc  = e.addr;
        n.dat = word_of(e.addr);
        mq.push_back(n);
      end
      prev_rst_low = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run(2);
    rst = 1'b1;
  endtask

  int rel;
  int base_acc;
  int base_fire;

  initial begin
    rst             = 1'b0;
    imem_req_ready  = 1'b1;
    instr_ready     = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #1;
    run(3);

    // Streaming at L=1: first instruction three cycles after reset release.
    rst      = 1'b1;
    rel      = cyc;
    first_iv = -1;
    run(12);
    chk("first_valid_cycle", 32'(first_iv - rel), 32'd3);
    chk("stream_fires", 32'(n_fire >= 8), 32'd1);

    // Decode stalled: exactly DEPTH requests, then release and resume.
    do_reset();
    instr_ready = 1'b0;
    base_acc    = n_acc;
    run(20);
    chk("stall_requests", 32'(n_acc - base_acc), 32'(DEPTH));
    instr_ready = 1'b1;
    base_fire   = n_fire;
    run(20);
    chk("drain_fires", 32'(n_fire - base_fire >= DEPTH), 32'd1);
    chk("fetch_resumed", 32'(n_acc - base_acc > DEPTH), 32'd1);

    // L=3, redirect to unaligned 0x103 with two requests in flight.
    lat = 3;
    do_reset();
    run(3);
    chk("inflight_before_redirect", 32'(memq.size()), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    run(15);

    // L=1 steady stream: redirect collides with a response and a decode handshake.
    lat = 1;
    do_reset();
    run(10);
    chk("collide_resp_pending", 32'(memq.size() > 0 && instr_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    run(10);

    // Back-to-back redirects during drain.
    lat = 3;
    run(4);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    run(15);

    // Address wrap, then reset in the middle of the stream.
    lat         = 2;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    run(10);
    chk("addr_wrap", 32'(saw_wrap), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        lat      = $urandom_range(5, 1);
        resp_pct = $urandom_range(100, 60);
      end
      rst            = ($urandom_range(499) != 0);
      imem_req_ready = ($urandom_range(3) != 0);
      instr_ready    = ($urandom_range(2) != 0);
      redirect       = ($urandom_range(24) == 0);
      redirect_pc    = $urandom;
      step();
    end
    rst      = 1'b1;
    redirect = 1'b0;
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
